// File: rtl/test_pkg.sv
// Shared types and constants for the detector test coincidence counter.
package test_pkg;

  localparam int WINDOW_WIDTH = 8;
  localparam int OVF_WIDTH    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2,
    S2   = 2'd3
  } out_state_t;

endpackage

// File: rtl/test_coincidence_detector.sv
// Edge detection on the two detector test bits, per-channel coincidence
// windows, and a single-cycle coincidence pulse.
module test_coincidence_detector
  import test_pkg::*;
(
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    enable,
  input  logic [1:0]              test_data,
  input  logic [WINDOW_WIDTH-1:0] cfg_window,
  output logic                    edge_a,
  output logic                    edge_b,
  output logic                    coinc
);

  logic [1:0]              prev;
  logic [WINDOW_WIDTH-1:0] win_a;
  logic [WINDOW_WIDTH-1:0] win_b;

  assign edge_a = test_data[0] & ~prev[0];
  assign edge_b = test_data[1] & ~prev[1];
  assign coinc  = (edge_a & (edge_b | (win_b != '0))) | (edge_b & (win_a != '0));

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prev <= '0;
    end else begin
      prev <= test_data;
    end
  end

  // A coincidence consumes both windows so one pulse pair never counts twice.
  always_ff @(posedge aclk) begin
    if (!aresetn || !enable || coinc) begin
      win_a <= '0;
      win_b <= '0;
    end else begin
      if (edge_a)            win_a <= cfg_window;
      else if (win_a != '0)  win_a <= win_a - WINDOW_WIDTH'(1);
      if (edge_b)            win_b <= cfg_window;
      else if (win_b != '0)  win_b <= win_b - WINDOW_WIDTH'(1);
    end
  end

endmodule

// File: rtl/test_coincidence_counter.sv
// Gated singles/coincidence counter emitting a three-word AXI4-Stream record
// {cnt_a, cnt_b, coinc} at the end of every gate period.
//
// state | meaning
// IDLE  | no record pending, tvalid low
// S0    | presenting cnt_a snapshot
// S1    | presenting cnt_b snapshot
// S2    | presenting coincidence snapshot, tlast high
module test_coincidence_counter
  import test_pkg::*;
#(
  parameter int CNTR_WIDTH   = 32,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              test_data,
  input  logic [PERIOD_WIDTH-1:0] cfg_period,
  input  logic [WINDOW_WIDTH-1:0] cfg_window,
  output logic [CNTR_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [OVF_WIDTH-1:0]    sts_overflow
);

  logic enable;
  logic edge_a, edge_b, coinc;
  logic terminal, snap_take, snap_drop;

  logic [PERIOD_WIDTH-1:0] period_cntr;
  logic [CNTR_WIDTH-1:0]   cnt_a, cnt_b, cnt_c;
  logic [CNTR_WIDTH-1:0]   cnt_a_nxt, cnt_b_nxt, cnt_c_nxt;
  logic [CNTR_WIDTH-1:0]   snap_a, snap_b, snap_c;

  out_state_t state, state_nxt;

  assign enable = (cfg_period != '0);

  test_coincidence_detector u_detector (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .enable     (enable),
    .test_data  (test_data),
    .cfg_window (cfg_window),
    .edge_a     (edge_a),
    .edge_b     (edge_b),
    .coinc      (coinc)
  );

  assign cnt_a_nxt = (edge_a && cnt_a != '1) ? cnt_a + CNTR_WIDTH'(1) : cnt_a;
  assign cnt_b_nxt = (edge_b && cnt_b != '1) ? cnt_b + CNTR_WIDTH'(1) : cnt_b;
  assign cnt_c_nxt = (coinc  && cnt_c != '1) ? cnt_c + CNTR_WIDTH'(1) : cnt_c;

  // Compare with >= so a period shortened below the running count ends at once.
  assign terminal  = enable && (period_cntr >= cfg_period - PERIOD_WIDTH'(1));
  assign snap_take = terminal && (state == IDLE || (state == S2 && m_axis_tready));
  assign snap_drop = terminal && !snap_take;

  always_ff @(posedge aclk) begin
    if (!aresetn || !enable || terminal) begin
      period_cntr <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      cnt_c       <= '0;
    end else begin
      period_cntr <= period_cntr + PERIOD_WIDTH'(1);
      cnt_a       <= cnt_a_nxt;
      cnt_b       <= cnt_b_nxt;
      cnt_c       <= cnt_c_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      snap_a <= '0;
      snap_b <= '0;
      snap_c <= '0;
    end else if (snap_take) begin
      snap_a <= cnt_a_nxt;
      snap_b <= cnt_b_nxt;
      snap_c <= cnt_c_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sts_overflow <= '0;
    end else if (snap_drop && sts_overflow != '1) begin
      sts_overflow <= sts_overflow + OVF_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        if (terminal) state_nxt = S0;
      end
      S0: begin
        m_axis_tdata  = snap_a;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_nxt = S1;
      end
      S1: begin
        m_axis_tdata  = snap_b;
        m_axis_tvalid = 1'b1;
        if (m_axis_tready) state_nxt = S2;
      end
      S2: begin
        m_axis_tdata  = snap_c;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        if (m_axis_tready) state_nxt = terminal ? S0 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_test_coincidence_counter.sv
// Directed bench for test_coincidence_counter; a second 8-bit instance covers
// counter saturation.
module tb_test_coincidence_counter;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;

  logic [1:0]  test_data = '0;
  logic [31:0] cfg_period = '0;
  logic [7:0]  cfg_window = '0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic [15:0] sts_overflow;

  logic [1:0]  test_data8 = '0;
  logic [31:0] cfg_period8 = '0;
  logic [7:0]  tdata8;
  logic        tvalid8, tlast8;
  logic        tready8 = 1'b1;
  logic [15:0] sts_overflow8;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  test_coincidence_counter #(.CNTR_WIDTH(32), .PERIOD_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn), .test_data(test_data),
    .cfg_period(cfg_period), .cfg_window(cfg_window),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .sts_overflow(sts_overflow)
  );

  test_coincidence_counter #(.CNTR_WIDTH(8), .PERIOD_WIDTH(32)) dut8 (
    .aclk(aclk), .aresetn(aresetn), .test_data(test_data8),
    .cfg_period(cfg_period8), .cfg_window(8'd0),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8),
    .m_axis_tlast(tlast8), .m_axis_tready(tready8),
    .sts_overflow(sts_overflow8)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    test_data = '0;
    test_data8 = '0;
    idle(2);
    aresetn = 1'b1;
  endtask

  task automatic pulse(input logic [1:0] bits);
    test_data = bits;
    step();
    test_data = 2'b00;
    step();
  endtask

  // Collects one three-word record; tlast is checked on every accepted word.
  task automatic wait_record(input bit sel8, input int budget,
                             output logic [31:0] w0, output logic [31:0] w1,
                             output logic [31:0] w2);
    logic [31:0] w [3];
    logic [31:0] td;
    logic tv, tl, tr;
    int idx = 0;
    w[0] = '0; w[1] = '0; w[2] = '0;
    for (int n = 0; n < budget && idx < 3; n++) begin
      tv = sel8 ? tvalid8 : m_axis_tvalid;
      tl = sel8 ? tlast8  : m_axis_tlast;
      tr = sel8 ? tready8 : m_axis_tready;
      td = sel8 ? {24'd0, tdata8} : m_axis_tdata;
      if (tv && tr) begin
        w[idx] = td;
        vectors++;
        if (tl !== (idx == 2)) begin
          miscompares++;
          $display("FAIL record_tlast word %0d: got %b want %b", idx, tl, (idx == 2));
        end
        idx++;
      end
      step();
    end
    vectors++;
    if (idx != 3) begin
      miscompares++;
      $display("FAIL record_timeout: got %0d words want 3 within %0d cycles", idx, budget);
    end
    w0 = w[0]; w1 = w[1]; w2 = w[2];
  endtask

  task automatic check_rec(input string name, input logic [31:0] g0, input logic [31:0] g1,
                           input logic [31:0] g2, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2);
    vectors++;
    if (g0 !== e0 || g1 !== e1 || g2 !== e2) begin
      miscompares++;
      $display("FAIL %s: got {%0d,%0d,%0d} want {%0d,%0d,%0d}", name, g0, g1, g2, e0, e1, e2);
    end
  endtask

  task automatic test_reset();
    cfg_period = 32'd0;
    do_reset();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0 ||
        sts_overflow !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%0d ovf=%0d want 0 0 0 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, sts_overflow);
    end
  endtask

  task automatic test_single_channel();
    logic [31:0] w0, w1, w2;
    cfg_period = 32'd100; cfg_window = 8'd0; m_axis_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) pulse(2'b01);
    wait_record(1'b0, 200, w0, w1, w2);
    check_rec("single_channel", w0, w1, w2, 32'd5, 32'd0, 32'd0);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_after_record_tvalid: got %b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] w0, w1, w2;
    cfg_period = 32'd100; cfg_window = 8'd0;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(2'b11);
    wait_record(1'b0, 200, w0, w1, w2);
    check_rec("same_cycle", w0, w1, w2, 32'd3, 32'd3, 32'd3);
  endtask

  task automatic test_window();
    logic [31:0] w0, w1, w2;
    cfg_period = 32'd100; cfg_window = 8'd4;
    do_reset();
    pulse(2'b01); idle(2); pulse(2'b10);               // B 4 cycles after A: counts
    idle(10);
    pulse(2'b01); idle(3); pulse(2'b10);               // 5 cycles: no count
    idle(10);
    pulse(2'b01); idle(2); pulse(2'b10); pulse(2'b10); // repeat B not recounted
    wait_record(1'b0, 200, w0, w1, w2);
    check_rec("window_bounds", w0, w1, w2, 32'd3, 32'd4, 32'd2);
  endtask

  task automatic test_back_to_back_overflow();
    logic [31:0] w0, w1, w2;
    cfg_period = 32'd3; cfg_window = 8'd0; m_axis_tready = 1'b0;
    do_reset();
    test_data = 2'b01;
    step();
    test_data = 2'b00;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i >= 2) begin
        vectors++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1 || m_axis_tlast !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: got v=%b d=%0d l=%b want 1 1 0",
                   i, m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        end
      end
    end
    vectors++;
    if (sts_overflow !== 16'd6) begin
      miscompares++;
      $display("FAIL bp_overflow: got %0d want 6", sts_overflow);
    end
    m_axis_tready = 1'b1;
    wait_record(1'b0, 10, w0, w1, w2);
    check_rec("bp_record", w0, w1, w2, 32'd1, 32'd0, 32'd0);
    vectors++;
    if (sts_overflow !== 16'd6) begin
      miscompares++;
      $display("FAIL bp_s2_accept_overflow: got %0d want 6", sts_overflow);
    end
  endtask

  task automatic test_disable();
    logic [31:0] w0, w1, w2;
    int seen = 0;
    cfg_period = 32'd1000; cfg_window = 8'd0; m_axis_tready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) pulse(2'b01);
    cfg_period = 32'd0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (m_axis_tvalid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL disable_no_record: got %0d valid cycles want 0", seen);
    end
    cfg_period = 32'd5;
    wait_record(1'b0, 20, w0, w1, w2);
    check_rec("disable_cleared", w0, w1, w2, 32'd0, 32'd0, 32'd0);
    cfg_period = 32'd0;
  endtask

  task automatic test_shrink();
    logic [31:0] w0, w1, w2;
    cfg_period = 32'd1000; cfg_window = 8'd0; m_axis_tready = 1'b1;
    do_reset();
    pulse(2'b01); pulse(2'b01);
    idle(46);                  // period_cntr now 50
    cfg_period = 32'd10;
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL shrink_early: got tvalid %b want 0", m_axis_tvalid);
    end
    step();
    vectors++;
    if (m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL shrink_latency: got tvalid %b want 1", m_axis_tvalid);
    end
    wait_record(1'b0, 5, w0, w1, w2);
    check_rec("shrink_record", w0, w1, w2, 32'd2, 32'd0, 32'd0);
    cfg_period = 32'd0;
  endtask

  task automatic test_saturation();
    logic [31:0] w0, w1, w2;
    cfg_period = 32'd0;
    cfg_period8 = 32'd700;
    tready8 = 1'b1;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      test_data8 = 2'b01;
      step();
      test_data8 = 2'b00;
      step();
    end
    wait_record(1'b1, 300, w0, w1, w2);
    check_rec("saturation8", w0, w1, w2, 32'd255, 32'd0, 32'd0);
    cfg_period8 = 32'd0;
  endtask

  task automatic test_reset_mid_record();
    cfg_period = 32'd5; cfg_window = 8'd0; m_axis_tready = 1'b1;
    do_reset();
    test_data = 2'b10;
    step();
    test_data = 2'b00;
    idle(4);
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_s0: got v=%b d=%0d want 1 0", m_axis_tvalid, m_axis_tdata);
    end
    step();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin
      miscompares++;
      $display("FAIL rst_s1: got v=%b d=%0d want 1 1", m_axis_tvalid, m_axis_tdata);
    end
    aresetn = 1'b0;
    step();
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_abandon: got v=%b l=%b d=%0d want 0 0 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata);
    end
    aresetn = 1'b1;
    step();
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_idle_after: got tvalid %b want 0", m_axis_tvalid);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_same_cycle();
    test_window();
    test_back_to_back_overflow();
    test_disable();
    test_shrink();
    test_saturation();
    test_reset_mid_record();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/test_coincidence_counter.md
# test_coincidence_counter

Counts rising edges on the two-bit detector test output (upper and lower detector halves) and the coincidences between them over a programmable gate period. At the end of each period it emits a three-word count record on an AXI4-Stream master. It sits directly downstream of the detector test reader and feeds a DMA/FIFO path to the processor.

## Interface
Parameters:
- CNTR_WIDTH, 32, width of the singles and coincidence counters and of m_axis_tdata.
- PERIOD_WIDTH, 32, width of cfg_period and of the period counter.

Ports:
- aclk  input  1  clock.
- aresetn  input  1  synchronous, active-low reset.
- test_data  input  2  test bits from the detector test reader. Bit 0 is channel A, bit 1 is channel B.
- cfg_period  input  PERIOD_WIDTH  gate period in aclk cycles. 0 disables counting.
- cfg_window  input  8  coincidence window in cycles.
- m_axis_tdata  output  CNTR_WIDTH  record word.
- m_axis_tvalid  output  1  record word valid.
- m_axis_tlast  output  1  high on the third word of a record.
- m_axis_tready  input  1  downstream ready.
- sts_overflow  output  16  count of dropped records, saturating.

## Operation
- test_data is registered once into prev.
- Edge rule: edge[i] = test_data[i] & ~prev[i], evaluated combinationally against the registered value.
- Window counters: win_a and win_b, 8 bits each.
  - An edge on a channel loads that channel's counter with cfg_window.
  - Otherwise a nonzero counter decrements by 1.
- Coincidence counter increments by 1 when either holds:
  - (edge_a and (edge_b or win_b≠0)), or
  - (edge_b and win_a≠0).
  - Simultaneous edges on both channels count as exactly one coincidence.
  - After a coincidence, both window counters are cleared to 0 (no reload that cycle). This prevents double counting.
  - cfg_window=0: only same-cycle edges coincide.
- Singles: cnt_a and cnt_b increment on edge_a and edge_b. All live counters saturate at 2^CNTR_WIDTH−1.
- Period counter:
  - Increments each cycle while cfg_period≠0.
  - Terminal cycle is when period_cntr ≥ cfg_period−1. A cfg_period reduced mid-period therefore terminates on the next cycle.
  - On the terminal cycle: snapshot ← {cnt_a, cnt_b, coinc} including that cycle's events; live counters and period_cntr clear to 0.
- cfg_period=0: period_cntr, live counters and window counters held at 0. No records are produced. An output record already in flight completes.
- Output FSM states:
  - IDLE → S0 on snapshot.
  - S0 (tdata=cnt_a) → S1 on tready.
  - S1 (tdata=cnt_b) → S2 on tready.
  - S2 (tdata=coinc, tlast=1) → IDLE on tready.
- Overflow: a snapshot arriving while the FSM is not IDLE is dropped and sts_overflow increments, saturating at 0xFFFF. A snapshot on the same cycle that S2 completes is accepted.
- tdata, tvalid and tlast are stable while tvalid=1 and tready=0.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, sts_overflow=0.
  - All counters 0, prev=0, FSM in IDLE.
  - Reset mid-record abandons the record.
- Edge latency: test_data rising before clock edge k is counted at edge k.
- Record latency:
  - The terminal cycle latches the snapshot at edge k. tvalid is high in the cycle after edge k.
  - With tready held at 1, the three words occupy cycles k+1..k+3.
- Minimum record spacing is 3 cycles, so cfg_period ≥ 3 with tready=1 never overflows.

## Structure
- Shared package test_pkg holds:
  - the output FSM state encoding (IDLE, S0, S1, S2);
  - the WINDOW_WIDTH=8 constant;
  - the OVF_WIDTH=16 constant.
- One sub-module, test_coincidence_detector, contains:
  - the edge detection;
  - the window counters;
  - the coincidence pulse.
  - It outputs edge_a, edge_b and coinc pulses. The top level holds the counters, the period logic and the stream FSM.

## Test plan
- Single-channel counting: cfg_period=100, cfg_window=0, 5 pulses on A only, tready=1. Expect record {5,0,0} with tlast on word 3.
- Same-cycle coincidence: cfg_window=0, A and B rise in the same cycle ×3. Expect {3,3,3}.
- Window boundaries: cfg_window=4.
  - B rises 4 cycles after A: counts.
  - B rises 5 cycles after A: does not count.
  - After a counted coincidence, a further B edge within 4 cycles is not counted again.
- Backpressure and overflow: cfg_period=3, tready=0 for 20 cycles. Expect word 0 held stable, sts_overflow increments once per dropped period, record contents from the first period.
- Disable and shrink:
  - cfg_period 1000→0 mid-period: counters hold at 0 and no record is produced.
  - cfg_period 1000→10 at period_cntr=50: record emitted the next cycle.
- Saturation and reset: force an A edge every other cycle for 2^CNTR_WIDTH periods (CNTR_WIDTH=8 build). Expect cnt_a stuck at 255. aresetn low mid-S1: tvalid=0 the next cycle, FSM in IDLE.
